// File: rtl/icache_pkg.sv
// icache_pkg: AXI read constants and AR channel state type shared by the iCache memory-side logic
package icache_pkg;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  typedef enum logic {AR_IDLE, AR_WAIT} ar_state_t;
endpackage

// File: rtl/icache_axi_rd_bridge.sv
// icache_axi_rd_bridge: turns per-word iCache fill requests into pipelined single-beat AXI4 reads
module icache_axi_rd_bridge
  import icache_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int AXI_ID          = 0,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_mem_req,
  input  logic [ADDR_WIDTH-1:0] i_mem_addr,
  output logic                  o_mem_addr_ok,
  output logic                  o_mem_data_ok,
  output logic [31:0]           o_mem_rdata,
  output logic [3:0]            o_arid,
  output logic [ADDR_WIDTH-1:0] o_araddr,
  output logic [7:0]            o_arlen,
  output logic [2:0]            o_arsize,
  output logic [1:0]            o_arburst,
  output logic                  o_arvalid,
  input  logic                  i_arready,
  input  logic [3:0]            i_rid,
  input  logic [31:0]           i_rdata,
  input  logic [1:0]            i_rresp,
  input  logic                  i_rlast,
  input  logic                  i_rvalid,
  output logic                  o_rready,
  output logic                  o_bus_err
);
  ar_state_t             r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic                  r_arvalid, r_bus_err;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  w_issue, w_ar_hs, w_r_dec, w_r_bad;

  assign w_ar_hs = r_arvalid && i_arready;
  // a beat only retires a read if one is actually outstanding
  assign w_r_dec = i_rvalid && i_rlast && r_cnt != '0;
  assign w_r_bad = i_rresp != AXI_RESP_OKAY || i_rid != 4'(AXI_ID) || !i_rlast || r_cnt == '0;

  always_comb begin
    w_issue     = r_state == AR_IDLE && i_mem_req && r_cnt < CNT_WIDTH'(MAX_OUTSTANDING);
    w_state_nxt = w_issue ? AR_WAIT : (w_ar_hs ? AR_IDLE : r_state);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= AR_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_arvalid <= 1'b0;
      r_araddr  <= '0;
      r_cnt     <= '0;
      r_bus_err <= 1'b0;
    end else begin
      if (w_issue) begin
        r_araddr  <= i_mem_addr & ~ADDR_WIDTH'(3);
        r_arvalid <= 1'b1;
      end else if (w_ar_hs) r_arvalid <= 1'b0;
      r_cnt     <= r_cnt + CNT_WIDTH'(w_ar_hs) - CNT_WIDTH'(w_r_dec);
      r_bus_err <= r_bus_err | (i_rvalid && w_r_bad);
    end
  end

  assign o_mem_addr_ok = w_ar_hs;
  assign o_mem_data_ok = i_rvalid;
  assign o_mem_rdata   = i_rdata;
  assign o_arid        = 4'(AXI_ID);
  assign o_araddr      = r_araddr;
  assign o_arlen       = 8'd0;
  assign o_arsize      = AXI_SIZE_4B;
  assign o_arburst     = AXI_BURST_INCR;
  assign o_arvalid     = r_arvalid;
  assign o_rready      = 1'b1;
  assign o_bus_err     = r_bus_err;
endmodule
